lc3_alu_sequencer: RTL and testbench

//  Multi-cycle execute controller for LC-3 operate instructions (ADD, AND, NOT) around LC3_alu.

---
 rtl/lc3_alu_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_lc3_alu_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_alu_sequencer.sv
// Multi-cycle execute controller for LC-3 operate instructions (ADD, AND, NOT).
// Sequences register-file reads, drives the combinational LC3_alu, writes back DR and updates NZP.
module lc3_alu_sequencer #(
  parameter logic [2:0] CC_RESET   = 3'b010,
  parameter bit         NOT_STRICT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  output logic [2:0]  rf_sr1_addr,
  output logic [2:0]  rf_sr2_addr,
  input  logic [15:0] rf_sr1_data,
  input  logic [15:0] rf_sr2_data,
  output logic [1:0]  alu_opcode,
  output logic        alu_sr2mux,
  output logic [4:0]  alu_imm5,
  output logic [15:0] alu_op_a,
  output logic [15:0] alu_op_b,
  input  logic [15:0] alu_result,
  output logic        rf_we,
  output logic [2:0]  rf_dr_addr,
  output logic [15:0] rf_wdata,
  output logic [2:0]  cc_nzp,
  output logic        done,
  output logic        illegal
);

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b1001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  state_t      state_r, next_state_s;
  logic [3:0]  op_r;
  logic [2:0]  dr_r;
  logic [5:0]  low_r;
  logic [15:0] op_a_r, op_b_r;
  logic        accept_s, legal_s, is_not_s;

  function automatic logic [2:0] nzp_of(input logic [15:0] value);
    logic [2:0] nzp;
    if (value[15]) begin
      nzp = 3'b100;
    end else if (value == 16'h0000) begin
      nzp = 3'b010;
    end else begin
      nzp = 3'b001;
    end
    return nzp;
  endfunction

  // Decode legality of the offered instruction and compute the next FSM state
  always_comb begin
    accept_s     = instr_valid && instr_ready;
    legal_s      = 1'b0;
    next_state_s = state_r;
    case (instr[15:12])
      OP_ADD, OP_AND: legal_s = 1'b1;
      OP_NOT:         legal_s = !NOT_STRICT || (instr[5:0] == 6'b111111);
      default:        legal_s = 1'b0;
    endcase
    case (state_r)
      IDLE: begin
        if (accept_s && legal_s) begin
          next_state_s = READ;
        end else begin
          next_state_s = IDLE;
        end
      end
      READ:    next_state_s = EXEC;
      EXEC:    next_state_s = WB;
      WB:      next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Operands follow the read data live during EXEC and hold their last value elsewhere
  always_comb begin
    is_not_s = (op_r == OP_NOT);
    if (state_r == EXEC) begin
      alu_op_a = rf_sr1_data;
      if (is_not_s) begin
        alu_op_b = rf_sr1_data;
      end else begin
        alu_op_b = rf_sr2_data;
      end
    end else begin
      alu_op_a = op_a_r;
      alu_op_b = op_b_r;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Registered datapath and handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_ready <= 1'b1;
      op_r        <= 4'd0;
      dr_r        <= 3'd0;
      low_r       <= 6'd0;
      rf_sr1_addr <= 3'd0;
      rf_sr2_addr <= 3'd0;
      alu_opcode  <= 2'b00;
      alu_sr2mux  <= 1'b0;
      alu_imm5    <= 5'd0;
      op_a_r      <= 16'h0000;
      op_b_r      <= 16'h0000;
      rf_we       <= 1'b0;
      done        <= 1'b0;
      illegal     <= 1'b0;
      rf_dr_addr  <= 3'd0;
      rf_wdata    <= 16'h0000;
      cc_nzp      <= CC_RESET;
    end else begin
      rf_we   <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s && legal_s) begin
            op_r        <= instr[15:12];
            dr_r        <= instr[11:9];
            low_r       <= instr[5:0];
            rf_sr1_addr <= instr[8:6];
            rf_sr2_addr <= instr[2:0];
            instr_ready <= 1'b0;
          end else if (accept_s) begin
            illegal <= 1'b1;
          end else begin
            instr_ready <= 1'b1;
          end
        end
        READ: begin
          if (is_not_s) begin
            alu_opcode <= 2'b10;
            alu_sr2mux <= 1'b0;
          end else if (op_r == OP_AND) begin
            alu_opcode <= 2'b01;
            alu_sr2mux <= low_r[5];
          end else begin
            alu_opcode <= 2'b00;
            alu_sr2mux <= low_r[5];
          end
          alu_imm5 <= low_r[4:0];
        end
        EXEC: begin
          op_a_r     <= alu_op_a;
          op_b_r     <= alu_op_b;
          rf_we      <= 1'b1;
          done       <= 1'b1;
          rf_dr_addr <= dr_r;
          rf_wdata   <= alu_result;
        end
        WB: begin
          cc_nzp      <= nzp_of(rf_wdata);
          instr_ready <= 1'b1;
        end
        default: begin
          instr_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_alu_sequencer.sv
// Randomized self-checking bench for lc3_alu_sequencer with a register-file and LC3_alu stand-in.
// Expected results come from an instruction-level model of the register file and condition codes.
module tb_lc3_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [2:0]  rf_sr1_addr, rf_sr2_addr;
  logic [15:0] rf_sr1_data, rf_sr2_data;
  logic [1:0]  alu_opcode;
  logic        alu_sr2mux;
  logic [4:0]  alu_imm5;
  logic [15:0] alu_op_a, alu_op_b, alu_result;
  logic        rf_we;
  logic [2:0]  rf_dr_addr;
  logic [15:0] rf_wdata;
  logic [2:0]  cc_nzp;
  logic        done, illegal;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_regs [8];
  logic [2:0]  exp_cc;
  logic [15:0] rf_mem [8];
  logic        load;

  lc3_alu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .rf_sr1_addr(rf_sr1_addr), .rf_sr2_addr(rf_sr2_addr),
    .rf_sr1_data(rf_sr1_data), .rf_sr2_data(rf_sr2_data), .alu_opcode(alu_opcode),
    .alu_sr2mux(alu_sr2mux), .alu_imm5(alu_imm5), .alu_op_a(alu_op_a),
    .alu_op_b(alu_op_b), .alu_result(alu_result), .rf_we(rf_we),
    .rf_dr_addr(rf_dr_addr), .rf_wdata(rf_wdata), .cc_nzp(cc_nzp),
    .done(done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Synchronous-read register file environment
  always @(posedge clk) begin
    rf_sr1_data <= rf_mem[rf_sr1_addr];
    rf_sr2_data <= rf_mem[rf_sr2_addr];
    if (load) begin
      for (int i = 0; i < 8; i++) rf_mem[i] <= exp_regs[i];
    end else if (rf_we) begin
      rf_mem[rf_dr_addr] <= rf_wdata;
    end
  end

  // LC3_alu stand-in: operand2 = op_a, operand0 = op_b, NOT inverts operand0
  always_comb begin
    logic [15:0] opnd;
    opnd = alu_sr2mux ? {{11{alu_imm5[4]}}, alu_imm5} : alu_op_b;
    case (alu_opcode)
      2'b00:   alu_result = alu_op_a + opnd;
      2'b01:   alu_result = alu_op_a & opnd;
      2'b10:   alu_result = ~alu_op_b;
      default: alu_result = 16'h0000;
    endcase
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] exp_nzp(input logic [15:0] v);
    if (v[15]) return 3'b100;
    if (v == 16'h0000) return 3'b010;
    return 3'b001;
  endfunction

  function automatic logic [15:0] rand_ir();
    logic [15:0] r;
    int k;
    r = 16'($urandom);
    k = $urandom_range(0, 9);
    if (k < 3) r[15:12] = 4'b0001;
    else if (k < 6) r[15:12] = 4'b0101;
    else if (k < 8) begin
      r[15:12] = 4'b1001;
      if ($urandom_range(0, 3) != 0) r[5:0] = 6'h3F;
    end
    return r;
  endfunction

  // Issue one instruction from an IDLE negedge and follow it to completion
  task automatic issue(input logic [15:0] ir, input bit hold, input logic [15:0] next_ir);
    logic [15:0] a, b, imm, res;
    logic [3:0]  op;
    logic        legal, is_not;
    op     = ir[15:12];
    a      = exp_regs[ir[8:6]];
    b      = exp_regs[ir[2:0]];
    imm    = {{11{ir[4]}}, ir[4:0]};
    is_not = (op == 4'b1001);
    legal  = (op == 4'b0001) || (op == 4'b0101) || (is_not && ir[5:0] == 6'h3F);
    case (op)
      4'b0001: res = a + (ir[5] ? imm : b);
      4'b0101: res = a & (ir[5] ? imm : b);
      4'b1001: res = ~a;
      default: res = 16'h0000;
    endcase
    check_eq("ready_idle", 16'(instr_ready), 16'd1);
    instr_valid = 1'b1;
    instr       = ir;
    @(negedge clk);
    if (!legal) begin
      instr_valid = 1'b0;
      check_eq("illegal_pulse", 16'(illegal), 16'd1);
      check_eq("illegal_ready", 16'(instr_ready), 16'd1);
      check_eq("illegal_we", 16'(rf_we), 16'd0);
      check_eq("illegal_cc", 16'(cc_nzp), 16'(exp_cc));
    end else begin
      instr_valid = hold;
      instr       = hold ? next_ir : 16'h0000;
      check_eq("read_ready", 16'(instr_ready), 16'd0);
      check_eq("read_illegal", 16'(illegal), 16'd0);
      check_eq("read_sr1", 16'(rf_sr1_addr), 16'(ir[8:6]));
      check_eq("read_sr2", 16'(rf_sr2_addr), 16'(ir[2:0]));
      @(negedge clk);
      check_eq("exec_ready", 16'(instr_ready), 16'd0);
      check_eq("exec_we", 16'(rf_we), 16'd0);
      check_eq("exec_op_a", alu_op_a, a);
      check_eq("exec_op_b", alu_op_b, is_not ? a : b);
      check_eq("exec_opcode", 16'(alu_opcode), is_not ? 16'd2 : (op == 4'b0101 ? 16'd1 : 16'd0));
      check_eq("exec_sr2mux", 16'(alu_sr2mux), is_not ? 16'd0 : 16'(ir[5]));
      if (!is_not) check_eq("exec_imm5", 16'(alu_imm5), 16'(ir[4:0]));
      @(negedge clk);
      check_eq("wb_we", 16'(rf_we), 16'd1);
      check_eq("wb_done", 16'(done), 16'd1);
      check_eq("wb_dr", 16'(rf_dr_addr), 16'(ir[11:9]));
      check_eq("wb_wdata", rf_wdata, res);
      check_eq("wb_cc_old", 16'(cc_nzp), 16'(exp_cc));
      check_eq("wb_ready", 16'(instr_ready), 16'd0);
      exp_regs[ir[11:9]] = res;
      exp_cc             = exp_nzp(res);
      @(negedge clk);
      check_eq("post_we", 16'(rf_we), 16'd0);
      check_eq("post_done", 16'(done), 16'd0);
      check_eq("post_ready", 16'(instr_ready), 16'd1);
      check_eq("post_cc", 16'(cc_nzp), 16'(exp_cc));
    end
  endtask

  initial begin
    logic [15:0] cur, nxt;
    bit          h;
    rst_n       = 1'b0;
    load        = 1'b1;
    instr_valid = 1'b0;
    instr       = 16'h0000;
    for (int i = 0; i < 8; i++) exp_regs[i] = 16'($urandom);
    exp_regs[2] = 16'd5;
    exp_regs[3] = 16'd7;
    exp_regs[4] = 16'd0;
    exp_regs[6] = 16'h00F0;
    exp_cc      = 3'b010;
    @(negedge clk);
    @(negedge clk);
    load = 1'b0;
    check_eq("rst_ready", 16'(instr_ready), 16'd1);
    check_eq("rst_we", 16'(rf_we), 16'd0);
    check_eq("rst_done", 16'(done), 16'd0);
    check_eq("rst_illegal", 16'(illegal), 16'd0);
    check_eq("rst_cc", 16'(cc_nzp), 16'd2);
    check_eq("rst_opcode", 16'(alu_opcode), 16'd0);
    check_eq("rst_wdata", rf_wdata, 16'h0000);
    check_eq("rst_op_a", alu_op_a, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);

    issue(16'h1283, 1'b0, 16'h0000);
    check_eq("dir_add_r1", exp_regs[1], 16'd12);
    issue(16'h193F, 1'b0, 16'h0000);
    issue(16'h5020, 1'b0, 16'h0000);
    issue(16'h9BBF, 1'b0, 16'h0000);
    issue(16'h9B80, 1'b0, 16'h0000);
    issue(16'h0000, 1'b0, 16'h0000);
    issue(16'h1283, 1'b1, 16'h5AA5);
    issue(16'h5AA5, 1'b0, 16'h0000);

    nxt = rand_ir();
    for (int i = 0; i < 200; i++) begin
      cur = nxt;
      nxt = rand_ir();
      h   = 1'($urandom_range(0, 1));
      issue(cur, h, nxt);
      if (!h) repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Reset while an ADD sits in EXEC must abort the write and restore the CCs
    issue(16'h5020, 1'b0, 16'h0000);
    issue(16'h923F, 1'b0, 16'h0000);
    instr_valid = 1'b1;
    instr       = 16'h1283;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("abort_ready", 16'(instr_ready), 16'd1);
    check_eq("abort_we", 16'(rf_we), 16'd0);
    check_eq("abort_cc", 16'(cc_nzp), 16'd2);
    @(negedge clk);
    check_eq("abort_we_hold", 16'(rf_we), 16'd0);
    check_eq("abort_done_hold", 16'(done), 16'd0);
    check_eq("abort_rf_r1", rf_mem[1], exp_regs[1]);
    rst_n  = 1'b1;
    exp_cc = 3'b010;
    @(negedge clk);
    issue(16'h1283, 1'b0, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
